// File: rtl/dbg_pkg.sv
// Shared types and constants for the debug instruction-substitution sequencer.
package dbg_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, CAPTURE} dbg_state_t;

    localparam logic [31:0] DBG_NOP = 32'h0000_0000;

endpackage

// File: rtl/dbg_drain_timer.sv
// Loadable down-counter that paces the NOP slots issued after an injected instruction.
module dbg_drain_timer #(
    parameter int W = 3
) (
    input  logic         cpu_clk,
    input  logic         ext_reset_n,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge cpu_clk or negedge ext_reset_n) begin
        if (!ext_reset_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/dbg_inject_ctrl.sv
// CPU-side sequencer: injects one debug instruction into fetch, drains the pipe
// with NOPs, then captures the COP0 status word and reports completion.
//
// state   | meaning
// IDLE    | waiting for a RUN pulse in debug mode
// ISSUE   | presenting the latched instruction until fetch accepts it
// DRAIN   | presenting NOPs until the drain timer expires
// CAPTURE | one settling cycle; status is sampled at its closing edge
module dbg_inject_ctrl
    import dbg_pkg::*;
#(
    parameter int          DRAIN_CYCLES = 4,
    parameter logic [31:0] NOP_WORD     = DBG_NOP,
    parameter int          CNT_W        = 16
) (
    input  logic             cpu_clk,
    input  logic             ext_reset_n,
    input  logic             dbg_mode,
    input  logic             dbg_run,
    input  logic [31:0]      dbg_idata,
    input  logic             pipe_stall,
    input  logic [31:0]      status_in,
    output logic             fetch_hold,
    output logic             inj_valid,
    output logic [31:0]      inj_instr,
    output logic             busy,
    output logic             done,
    output logic [31:0]      status_out,
    output logic             overrun,
    output logic [CNT_W-1:0] exec_cnt
);

    localparam int              TMR_W    = $clog2(DRAIN_CYCLES) + 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(DRAIN_CYCLES - 1);

    dbg_state_t  state_q, state_d;
    logic [31:0] instr_q;
    logic        mode_q;
    logic        tmr_zero;
    logic        accept;

    assign fetch_hold = dbg_mode;
    assign accept     = (state_q == IDLE) && dbg_mode && dbg_run;

    dbg_drain_timer #(.W(TMR_W)) u_drain_timer (
        .cpu_clk     (cpu_clk),
        .ext_reset_n (ext_reset_n),
        .load        ((state_q == ISSUE) && !pipe_stall),
        .en          ((state_q == DRAIN) && !pipe_stall),
        .load_val    (TMR_LOAD),
        .zero        (tmr_zero)
    );

    always_ff @(posedge cpu_clk or negedge ext_reset_n) begin
        if (!ext_reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Leaving debug mode aborts any sequence in flight, including the capture cycle.
    always_comb begin
        state_d = state_q;
        if ((state_q != IDLE) && !dbg_mode) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (accept) state_d = ISSUE;
                ISSUE:   if (!pipe_stall) state_d = DRAIN;
                DRAIN:   if (!pipe_stall && tmr_zero) state_d = CAPTURE;
                CAPTURE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        inj_valid = 1'b0;
        inj_instr = '0;
        busy      = (state_q != IDLE);
        case (state_q)
            ISSUE: begin
                inj_valid = 1'b1;
                inj_instr = instr_q;
            end
            DRAIN: begin
                inj_valid = 1'b1;
                inj_instr = NOP_WORD;
            end
            default: ;
        endcase
    end

    always_ff @(posedge cpu_clk or negedge ext_reset_n) begin
        if (!ext_reset_n) begin
            instr_q    <= '0;
            mode_q     <= 1'b0;
            done       <= 1'b0;
            status_out <= '0;
            overrun    <= 1'b0;
            exec_cnt   <= '0;
        end else begin
            mode_q <= dbg_mode;
            done   <= 1'b0;
            if (accept) begin
                instr_q <= dbg_idata;
            end
            if ((state_q == CAPTURE) && dbg_mode) begin
                done       <= 1'b1;
                status_out <= status_in;
                exec_cnt   <= exec_cnt + CNT_W'(1);
            end
            if (mode_q && !dbg_mode) begin
                overrun <= 1'b0;
            end else if (dbg_run && busy) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dbg_inject_ctrl.sv
// Bench for dbg_inject_ctrl: directed scenarios plus random traffic, compared
// every cycle against a slot-counting reference model.
module tb_dbg_inject_ctrl;

    localparam int          D   = 4;
    localparam int          CW  = 2;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic          cpu_clk;
    logic          ext_reset_n;
    logic          dbg_mode;
    logic          dbg_run;
    logic [31:0]   dbg_idata;
    logic          pipe_stall;
    logic [31:0]   status_in;
    logic          fetch_hold;
    logic          inj_valid;
    logic [31:0]   inj_instr;
    logic          busy;
    logic          done;
    logic [31:0]   status_out;
    logic          overrun;
    logic [CW-1:0] exec_cnt;

    dbg_inject_ctrl #(
        .DRAIN_CYCLES (D),
        .NOP_WORD     (NOP),
        .CNT_W        (CW)
    ) dut (
        .cpu_clk     (cpu_clk),
        .ext_reset_n (ext_reset_n),
        .dbg_mode    (dbg_mode),
        .dbg_run     (dbg_run),
        .dbg_idata   (dbg_idata),
        .pipe_stall  (pipe_stall),
        .status_in   (status_in),
        .fetch_hold  (fetch_hold),
        .inj_valid   (inj_valid),
        .inj_instr   (inj_instr),
        .busy        (busy),
        .done        (done),
        .status_out  (status_out),
        .overrun     (overrun),
        .exec_cnt    (exec_cnt)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: an operation is a sequence of fetch slots; slot 0 is the instruction,
    // slots 1..D are NOPs, and once D+1 slots are taken one settling cycle follows.
    bit          m_busy;
    int          m_slots;
    logic [31:0] m_word;
    bit          m_done;
    logic [31:0] m_status;
    bit          m_over;
    bit          m_mode_prev;
    int          m_execs;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_slots = 0; m_word = '0; m_done = 0;
        m_status = '0; m_over = 0; m_mode_prev = 0; m_execs = 0;
    endtask

    task automatic model_edge();
        bit was_busy;
        was_busy = m_busy;
        m_done   = 0;
        if (m_busy && !dbg_mode) begin
            m_busy = 0;
        end else if (m_busy) begin
            if (m_slots == D + 1) begin
                m_done   = 1;
                m_status = status_in;
                m_execs++;
                m_busy   = 0;
            end else if (!pipe_stall) begin
                m_slots++;
            end
        end else if (dbg_mode && dbg_run) begin
            m_busy  = 1;
            m_slots = 0;
            m_word  = dbg_idata;
        end
        if (m_mode_prev && !dbg_mode) m_over = 0;
        else if (dbg_run && was_busy) m_over = 1;
        m_mode_prev = dbg_mode;
    endtask

    task automatic compare_all();
        logic        e_valid;
        logic [31:0] e_instr;
        e_valid = m_busy && (m_slots <= D);
        e_instr = !e_valid ? 32'h0 : ((m_slots == 0) ? m_word : NOP);
        check("inj_valid",  {31'b0, inj_valid},  {31'b0, e_valid});
        check("inj_instr",  inj_instr,           e_instr);
        check("busy",       {31'b0, busy},       {31'b0, m_busy});
        check("done",       {31'b0, done},       {31'b0, m_done});
        check("status_out", status_out,          m_status);
        check("overrun",    {31'b0, overrun},    {31'b0, m_over});
        check("exec_cnt",   {30'b0, exec_cnt},   32'(m_execs % (1 << CW)));
        check("fetch_hold", {31'b0, fetch_hold}, {31'b0, dbg_mode});
    endtask

    task automatic step();
        @(posedge cpu_clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        ext_reset_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(posedge cpu_clk);
        @(posedge cpu_clk);
        #3;
        ext_reset_n = 1'b1;
    endtask

    // Caller raises dbg_run for cycle 0; returns the cycle in which DONE is seen (-1 if none).
    task automatic wait_done(input int budget, input logic [31:0] stall_mask,
                             input int run2_at, input int drop_at,
                             output int at, output logic [31:0] st_pre);
        at     = -1;
        st_pre = '0;
        for (int i = 1; i <= budget; i++) begin
            step();
            if (done) begin
                at     = i;
                st_pre = status_in;
                break;
            end
            dbg_run    = (i == run2_at);
            pipe_stall = (i < 32) ? stall_mask[i] : 1'b0;
            if (i == drop_at) dbg_mode = 1'b0;
            status_in  = $urandom;
        end
        dbg_run = 1'b0;
    endtask

    int          at;
    logic [31:0] st_pre;
    int          exp_cnt [5] = '{1, 2, 3, 0, 1};

    initial begin
        dbg_mode = 0; dbg_run = 0; dbg_idata = '0; pipe_stall = 0; status_in = '0;
        ext_reset_n = 0;
        do_reset();
        dbg_mode = 1'b1;
        step();

        // 1: plain injection
        dbg_idata = 32'h3404_8001; dbg_run = 1'b1; status_in = $urandom;
        wait_done(20, 32'h0, 0, 0, at, st_pre);
        check("t1_done_cycle", at, 7);
        check("t1_exec_cnt", {30'b0, exec_cnt}, 1);

        // 2: stalls in cycles 1 and 3
        dbg_idata = 32'h3404_8001; dbg_run = 1'b1;
        wait_done(20, 32'b1010, 0, 0, at, st_pre);
        check("t2_done_cycle", at, 9);
        check("t2_status", status_out, st_pre);

        // 3: second RUN while busy
        dbg_idata = $urandom; dbg_run = 1'b1;
        wait_done(20, 32'h0, 3, 0, at, st_pre);
        check("t3_done_cycle", at, 7);
        check("t3_overrun", {31'b0, overrun}, 1);
        wait_done(6, 32'h0, 0, 0, at, st_pre);
        check("t3_single_done", at, -1);
        dbg_mode = 1'b0;
        step();
        check("t3_overrun_clr", {31'b0, overrun}, 0);
        dbg_mode = 1'b1;
        step();

        // 4: mode drops during DRAIN
        dbg_idata = $urandom; dbg_run = 1'b1;
        wait_done(5, 32'h0, 0, 4, at, st_pre);
        check("t4_busy_c5", {31'b0, busy}, 0);
        check("t4_fetch_hold", {31'b0, fetch_hold}, 0);
        wait_done(8, 32'h0, 0, 0, at, st_pre);
        check("t4_no_done", at, -1);
        check("t4_exec_cnt", {30'b0, exec_cnt}, 3);
        dbg_mode = 1'b1;
        step();

        // 5: reset during ISSUE
        dbg_idata = $urandom; dbg_run = 1'b1;
        step();
        dbg_run = 1'b0;
        check("t5_in_issue", {31'b0, inj_valid}, 1);
        #2 ext_reset_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        check("t5_rst_instr", inj_instr, 0);
        @(posedge cpu_clk);
        #3 ext_reset_n = 1'b1;
        dbg_idata = $urandom; dbg_run = 1'b1;
        wait_done(20, 32'h0, 0, 0, at, st_pre);
        check("t5_done_cycle", at, 7);
        check("t5_exec_cnt", {30'b0, exec_cnt}, 1);

        // 6: back-to-back runs with wrap
        do_reset();
        dbg_mode = 1'b1;
        step();
        dbg_run = 1'b1;
        for (int k = 0; k < 5; k++) begin
            dbg_idata = $urandom;
            dbg_run   = 1'b1;
            wait_done(20, 32'h0, 0, 0, at, st_pre);
            check("t6_done_cycle", at, 7);
            check("t6_exec_cnt", {30'b0, exec_cnt}, 32'(exp_cnt[k]));
        end
        dbg_mode = 1'b0; dbg_run = 1'b1;
        step();
        dbg_run = 1'b0;
        step();
        check("t6_mode0_valid", {31'b0, inj_valid}, 0);
        check("t6_mode0_busy", {31'b0, busy}, 0);

        // random traffic
        dbg_mode = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(39) == 0) dbg_mode = ~dbg_mode;
            dbg_run    = ($urandom_range(5) == 0);
            pipe_stall = ($urandom_range(3) == 0);
            dbg_idata  = $urandom;
            status_in  = $urandom;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
